// File: rtl/instr_queue.sv
// Prefetch queue in front of an instruction register stage.
// The memory side pushes words; the control unit consumes the IR with ir_adv.
module instr_queue #(
  parameter int INSTR_W = 16,
  parameter int FIELD_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [INSTR_W-1:0]         in_data,
  output logic                       in_ready,
  input  logic                       ir_adv,
  input  logic                       flush,
  output logic                       ir_valid,
  output logic [INSTR_W-1:0]         ir_data,
  output logic [FIELD_W-1:0]         instr_op,
  output logic [FIELD_W-1:0]         instr_a,
  output logic [FIELD_W-1:0]         instr_b,
  output logic [FIELD_W-1:0]         instr_c,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic               ir_valid_reg;
  logic [INSTR_W-1:0] ir_data_reg;

  logic fire;
  logic take;
  logic pop;
  logic bypass;
  logic push;
  logic q_nonempty;

  assign q_nonempty = (count_reg != '0);
  assign in_ready   = rst_n & ~flush & (count_reg < CW'(DEPTH));
  assign fire       = in_valid & in_ready;
  assign take       = ~ir_valid_reg | ir_adv;
  assign pop        = take & q_nonempty & ~flush;
  // A word arriving while the IR is free and nothing is queued skips the queue.
  assign bypass     = take & ~q_nonempty & fire;
  assign push       = fire & ~bypass;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ir_valid_reg <= 1'b0;
      ir_data_reg  <= '0;
    end else if (flush) begin
      // ir_data is deliberately kept; consumers qualify it with ir_valid.
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ir_valid_reg <= 1'b0;
    end else begin
      if (take) begin
        if (q_nonempty) begin
          ir_data_reg  <= mem[rd_ptr_reg];
          ir_valid_reg <= 1'b1;
        end else if (fire) begin
          ir_data_reg  <= in_data;
          ir_valid_reg <= 1'b1;
        end else begin
          ir_valid_reg <= 1'b0;
        end
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign ir_valid = ir_valid_reg;
  assign ir_data  = ir_data_reg;
  assign q_count  = count_reg;
  assign instr_op = ir_data_reg[INSTR_W-1 -: FIELD_W];
  assign instr_a  = ir_data_reg[INSTR_W-FIELD_W-1 -: FIELD_W];
  assign instr_b  = ir_data_reg[2*FIELD_W-1 -: FIELD_W];
  assign instr_c  = ir_data_reg[FIELD_W-1:0];

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: the IR plus queue is modelled as one
// ordered list whose head is the IR word.
module tb_instr_queue;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [INSTR_W-1:0] in_data = '0;
  logic               in_ready;
  logic               ir_adv = 1'b0;
  logic               flush = 1'b0;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic [FIELD_W-1:0] instr_op, instr_a, instr_b, instr_c;
  logic [$clog2(DEPTH):0] q_count;

  int total = 0;
  int bad = 0;

  logic [INSTR_W-1:0] model_q [$];
  logic [INSTR_W-1:0] last_ir = '0;

  instr_queue #(.INSTR_W(INSTR_W), .FIELD_W(FIELD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ir_adv(ir_adv), .flush(flush),
    .ir_valid(ir_valid), .ir_data(ir_data), .instr_op(instr_op),
    .instr_a(instr_a), .instr_b(instr_b), .instr_c(instr_c), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count();
    return (model_q.size() > 0) ? model_q.size() - 1 : 0;
  endfunction

  task automatic check_state();
    logic [INSTR_W-1:0] e;
    e = last_ir;
    chk("ir_valid", ir_valid, model_q.size() > 0);
    chk("q_count", q_count, model_count());
    chk("ir_data", ir_data, e);
    chk("instr_op", instr_op, e[15:12]);
    chk("instr_a", instr_a, e[11:8]);
    chk("instr_b", instr_b, e[7:4]);
    chk("instr_c", instr_c, e[3:0]);
  endtask

  // One clock: drive at negedge, predict, then compare just after the rising edge.
  task automatic step(input logic v, input logic [INSTR_W-1:0] d, input logic adv, input logic fl);
    logic rdy;
    @(negedge clk);
    in_valid = v; in_data = d; ir_adv = adv; flush = fl;
    #1;
    rdy = !fl && (model_count() < DEPTH);
    chk("in_ready", in_ready, rdy);
    if (fl) begin
      model_q.delete();
    end else begin
      if (adv && model_q.size() > 0) begin
        chk("consume", ir_data, model_q[0]);
        void'(model_q.pop_front());
      end
      if (v && rdy) model_q.push_back(d);
    end
    if (model_q.size() > 0) last_ir = model_q[0];
    @(posedge clk);
    #1;
    $display("cyc v=%0b d=%h adv=%0b fl=%0b -> ir_valid=%0b ir=%h q=%0d",
             v, d, adv, fl, ir_valid, ir_data, q_count);
    check_state();
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_data", ir_data, 0);
    chk("rst_fields", {instr_op, instr_a, instr_b, instr_c}, 0);
    chk("rst_q_count", q_count, 0);
  endtask

  initial begin
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass into an empty IR: 1-cycle latency, fields 1/2/3/4.
    step(1, 16'h1234, 0, 0);
    chk("op_1234", instr_op, 4'h1);
    chk("c_1234", instr_c, 4'h4);

    // Fill queue while IR holds; fifth word is refused.
    for (int i = 1; i <= 4; i++) step(1, 16'hA000 + 16'(i), 0, 0);
    step(1, 16'hA005, 0, 0);
    chk("full_ir_hold", ir_data, 16'h1234);

    // Drain with advance; A005 offered until accepted.
    step(1, 16'hA005, 1, 0);
    step(1, 16'hA005, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 1, 0);

    // q_count=2 then simultaneous push and advance.
    for (int i = 1; i <= 3; i++) step(1, 16'hB000 + 16'(i), 0, 0);
    step(1, 16'hB004, 1, 0);
    chk("pushadv_head", ir_data, 16'hB002);

    // Flush with q_count=3 and a word offered.
    step(1, 16'hB005, 0, 0);
    step(1, 16'hC000, 0, 1);
    step(1, 16'h5555, 0, 0);
    chk("post_flush", ir_data, 16'h5555);

    // Async reset mid-stream with q_count=2.
    step(1, 16'h6001, 0, 0);
    step(1, 16'h6002, 0, 0);
    step(0, 16'h0000, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_q.delete();
    last_ir = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'h7777, 0, 0);

    // Random traffic.
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < DEPTH + 2; i++) step(0, 16'h0000, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
